// File: rtl/edid_ctl_pkg.sv
// Shared types and default timing for the DDC/EDID controller (25 MHz system clock).
package edid_ctl_pkg;

  typedef enum logic [2:0] {
    DISC,
    HPD_LOW,
    START,
    WAIT_OK,
    RECOVER,
    CONNECTED,
    FAILED
  } seq_state_e;

  localparam int DEF_DEBOUNCE_CYC = 250000;
  localparam int DEF_HPD_LOW_CYC  = 2500000;
  localparam int DEF_TIMEOUT_CYC  = 12500000;
  localparam int DEF_RST_CYC      = 16;
  localparam int DEF_MAX_RETRY    = 3;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hpd_debounce.sv
// Two-flop synchroniser and debounce filter for the monitor hot-plug line.
// The output only changes after the synchronised input has disagreed with it
// for DEBOUNCE_CYC consecutive cycles, so short glitches never get through.
module hpd_debounce
  import edid_ctl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic gclk,
  input  logic rst,
  input  logic hpd_i,
  output logic level_o
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC) + 1;

  logic [1:0]      sync_q;
  logic            level_q, level_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  // Bring the asynchronous hot-plug level into the gclk domain.
  always_ff @(posedge gclk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], hpd_i};
    end
  end

  // Count consecutive disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q >= DB_W'(DEBOUNCE_CYC - 1)) begin
        level_d = ~level_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounced level and its stability counter.
  always_ff @(posedge gclk or negedge rst) begin
    if (!rst) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/edid_hpd_sequencer.sv
// EDID pass-through sequencer: debounces monitor hot-plug, resets and launches
// the EDID engine, supervises each fetch with a timeout and bounded retries,
// and raises source-side HPD only once a fresh EDID image has been fetched.
module edid_hpd_sequencer
  import edid_ctl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int HPD_LOW_CYC  = DEF_HPD_LOW_CYC,
  parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
  parameter int RST_CYC      = DEF_RST_CYC,
  parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
  input  logic                           gclk,
  input  logic                           rst,
  input  logic                           sink_hpd,
  input  logic                           force_refresh,
  output logic                           edid_rst_n,
  output logic                           edid_init,
  input  logic                           edid_ok,
  output logic                           src_hpd,
  output logic                           busy,
  output logic                           fail,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);

  localparam int RETRY_W   = $clog2(MAX_RETRY + 1);
  localparam int MAX_PHASE = max_of(max_of(HPD_LOW_CYC, TIMEOUT_CYC), RST_CYC);
  localparam int CNT_W     = $clog2(MAX_PHASE) + 1;

  localparam logic [CNT_W-1:0]   HPD_LAST   = CNT_W'(HPD_LOW_CYC - 1);
  localparam logic [CNT_W-1:0]   TO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]   RST_LAST   = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0]   RST_LEN    = CNT_W'(RST_CYC);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);

  logic hpd_db;

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic fail_q, fail_d;
  logic rstn_q, rstn_d;
  logic init_q, init_d;
  logic src_q, src_d;
  logic busy_q, busy_d;

  hpd_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .gclk   (gclk),
    .rst    (rst),
    .hpd_i  (sink_hpd),
    .level_o(hpd_db)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // Next-state logic; outputs are decoded from the next state so they are registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    retry_d = retry_q;
    fail_d  = fail_q;

    case (state_q)
      DISC: begin
        cnt_d = '0;
        if (hpd_db) begin
          state_d = HPD_LOW;
        end
      end
      HPD_LOW: begin
        if (cnt_q >= HPD_LAST) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        state_d = WAIT_OK;
        cnt_d   = '0;
      end
      WAIT_OK: begin
        if (edid_ok) begin
          state_d = CONNECTED;
          cnt_d   = '0;
        end else if (cnt_q >= TO_LAST) begin
          cnt_d = '0;
          if (retry_q < RETRY_LAST) begin
            retry_d = retry_q + 1'b1;
            state_d = RECOVER;
          end else begin
            state_d = FAILED;
          end
        end
      end
      RECOVER: begin
        if (cnt_q >= RST_LAST) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      CONNECTED: begin
        cnt_d = '0;
        if (force_refresh) begin
          state_d = HPD_LOW;
        end
      end
      FAILED: begin
        cnt_d = '0;
        if (force_refresh) begin
          state_d = HPD_LOW;
        end
      end
      default: begin
        state_d = DISC;
        cnt_d   = '0;
      end
    endcase

    if (!hpd_db) begin
      state_d = DISC;
      cnt_d   = '0;
      retry_d = retry_q;
    end

    if (state_d == HPD_LOW && state_q != HPD_LOW) begin
      cnt_d   = '0;
      retry_d = '0;
      fail_d  = 1'b0;
    end

    if (state_d == FAILED) begin
      fail_d = 1'b1;
    end

    busy_d = (state_d == HPD_LOW) || (state_d == START) ||
             (state_d == WAIT_OK) || (state_d == RECOVER);
    src_d  = (state_d == CONNECTED);
    init_d = (state_d == START);
    rstn_d = !((state_d == DISC) || (state_d == FAILED) ||
               (((state_d == HPD_LOW) || (state_d == RECOVER)) && (cnt_d < RST_LEN)));
  end

  // State, phase counter, retry bookkeeping and registered outputs.
  always_ff @(posedge gclk or negedge rst) begin
    if (!rst) begin
      state_q <= DISC;
      cnt_q   <= '0;
      retry_q <= '0;
      fail_q  <= 1'b0;
      rstn_q  <= 1'b0;
      init_q  <= 1'b0;
      src_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      fail_q  <= fail_d;
      rstn_q  <= rstn_d;
      init_q  <= init_d;
      src_q   <= src_d;
      busy_q  <= busy_d;
    end
  end

  assign edid_rst_n = rstn_q;
  assign edid_init  = init_q;
  assign src_hpd    = src_q;
  assign busy       = busy_q;
  assign fail       = fail_q;
  assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_edid_hpd_sequencer.sv
// Directed bench for edid_hpd_sequencer with short timing parameters.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_edid_hpd_sequencer;

  localparam int DEBOUNCE_CYC = 8;
  localparam int HPD_LOW_CYC  = 32;
  localparam int TIMEOUT_CYC  = 64;
  localparam int RST_CYC      = 4;
  localparam int MAX_RETRY    = 2;

  logic       gclk = 1'b0;
  logic       rst;
  logic       sink_hpd;
  logic       force_refresh;
  logic       edid_ok;
  logic       edid_rst_n;
  logic       edid_init;
  logic       src_hpd;
  logic       busy;
  logic       fail;
  logic [1:0] retry_cnt;

  int checks    = 0;
  int failures  = 0;
  int initCount = 0;
  int n;

  edid_hpd_sequencer #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .HPD_LOW_CYC (HPD_LOW_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .RST_CYC     (RST_CYC),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .gclk         (gclk),
    .rst          (rst),
    .sink_hpd     (sink_hpd),
    .force_refresh(force_refresh),
    .edid_rst_n   (edid_rst_n),
    .edid_init    (edid_init),
    .edid_ok      (edid_ok),
    .src_hpd      (src_hpd),
    .busy         (busy),
    .fail         (fail),
    .retry_cnt    (retry_cnt)
  );

  always #5 gclk = ~gclk;

  // Count every fetch-start pulse the sequencer issues.
  always @(posedge gclk) begin
    #1;
    if (edid_init === 1'b1) initCount++;
  end

  task automatic tick(input int cycles);
    repeat (cycles) @(negedge gclk);
  endtask

  task automatic applyStimulus(input logic hpd, input logic refresh, input logic ok);
    sink_hpd      = hpd;
    force_refresh = refresh;
    edid_ok       = ok;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic waitInit(input int budget, output int cycles);
    cycles = 0;
    while (edid_init !== 1'b1 && cycles < budget) begin
      tick(1);
      cycles++;
    end
  endtask

  task automatic waitBusy(input logic lvl, input int budget, output int cycles);
    cycles = 0;
    while (busy !== lvl && cycles < budget) begin
      tick(1);
      cycles++;
    end
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(3);
    $display("[TB] reset values");
    checkOutput("rst_edid_rst_n", edid_rst_n, 0);
    checkOutput("rst_edid_init", edid_init, 0);
    checkOutput("rst_src_hpd", src_hpd, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_fail", fail, 0);
    checkOutput("rst_retry_cnt", retry_cnt, 0);
    rst = 1'b1;
    tick(2);

    $display("[TB] glitch rejection");
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick(5);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(30);
    checkOutput("glitch_busy", busy, 0);
    checkOutput("glitch_src_hpd", src_hpd, 0);
    checkOutput("glitch_no_init", initCount, 0);
    checkOutput("glitch_edid_rst_n", edid_rst_n, 0);

    $display("[TB] plug-in success");
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitBusy(1'b1, 40, n);
    checkOutput("plug_latency", n, 11);
    checkOutput("plug_rstn_k0", edid_rst_n, 0);
    tick(3);
    checkOutput("plug_rstn_k3", edid_rst_n, 0);
    tick(1);
    checkOutput("plug_rstn_k4", edid_rst_n, 1);
    waitInit(40, n);
    checkOutput("plug_init_k32", n, 28);
    checkOutput("plug_init_count", initCount, 1);
    checkOutput("plug_src_before", src_hpd, 0);
    checkOutput("plug_busy_fetch", busy, 1);
    tick(1);
    checkOutput("plug_init_one_cycle", edid_init, 0);
    tick(19);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("plug_src_at_ok", src_hpd, 0);
    tick(1);
    checkOutput("plug_src_after_ok", src_hpd, 1);
    checkOutput("plug_busy_done", busy, 0);
    checkOutput("plug_retry_cnt", retry_cnt, 0);
    checkOutput("plug_fail", fail, 0);

    $display("[TB] refresh while connected, edid_ok on last wait cycle");
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("refresh_src_low", src_hpd, 0);
    checkOutput("refresh_busy", busy, 1);
    waitInit(50, n);
    checkOutput("refresh_low_cycles", n, 32);
    checkOutput("refresh_init_count", initCount, 2);
    tick(64);
    checkOutput("edge63_still_waiting", edid_rst_n, 1);
    checkOutput("edge63_busy", busy, 1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick(1);
    checkOutput("edge63_connected", src_hpd, 1);
    checkOutput("edge63_retry_cnt", retry_cnt, 0);

    $display("[TB] timeout and retries");
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitInit(50, n);
    checkOutput("to_first_init", n, 32);
    tick(64);
    checkOutput("to_wait_last", edid_rst_n, 1);
    tick(1);
    checkOutput("to_recover_rstn", edid_rst_n, 0);
    checkOutput("to_retry_1", retry_cnt, 1);
    checkOutput("to_recover_src", src_hpd, 0);
    checkOutput("to_recover_busy", busy, 1);
    tick(3);
    checkOutput("to_recover_rstn_end", edid_rst_n, 0);
    waitInit(10, n);
    checkOutput("to_second_init", n, 1);
    tick(65);
    checkOutput("to_retry_2", retry_cnt, 2);
    waitInit(10, n);
    checkOutput("to_third_init", n, 4);
    checkOutput("to_three_inits", initCount, 5);
    tick(64);
    checkOutput("to_fail_not_yet", fail, 0);
    tick(1);
    checkOutput("to_fail", fail, 1);
    checkOutput("to_fail_retry", retry_cnt, 2);
    checkOutput("to_fail_src", src_hpd, 0);
    checkOutput("to_fail_busy", busy, 0);
    checkOutput("to_fail_rstn", edid_rst_n, 0);
    tick(20);
    checkOutput("to_no_more_inits", initCount, 5);
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("restart_fail_clear", fail, 0);
    checkOutput("restart_busy", busy, 1);
    checkOutput("restart_retry_clear", retry_cnt, 0);

    $display("[TB] recovery on second attempt");
    waitInit(50, n);
    checkOutput("rec_first_init", n, 32);
    tick(65);
    checkOutput("rec_recover_rstn", edid_rst_n, 0);
    checkOutput("rec_retry_1", retry_cnt, 1);
    waitInit(10, n);
    checkOutput("rec_second_init", n, 4);
    tick(10);
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick(1);
    checkOutput("rec_connected", src_hpd, 1);
    checkOutput("rec_retry_cnt", retry_cnt, 1);
    checkOutput("rec_fail", fail, 0);
    checkOutput("rec_busy", busy, 0);

    $display("[TB] unplug during fetch");
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitInit(50, n);
    checkOutput("unplug_init", n, 32);
    tick(10);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitBusy(1'b0, 40, n);
    checkOutput("unplug_latency", n, 11);
    checkOutput("unplug_rstn", edid_rst_n, 0);
    checkOutput("unplug_src", src_hpd, 0);
    checkOutput("unplug_init_low", edid_init, 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(5);
    checkOutput("late_ok_src", src_hpd, 0);
    checkOutput("late_ok_busy", busy, 0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(2);
    checkOutput("disc_refresh_ignored", busy, 0);
    checkOutput("disc_refresh_rstn", edid_rst_n, 0);

    $display("[TB] asynchronous reset mid-sequence");
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitBusy(1'b1, 40, n);
    checkOutput("replug_latency", n, 11);
    tick(10);
    checkOutput("replug_rstn", edid_rst_n, 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_busy", busy, 0);
    checkOutput("async_rst_rstn", edid_rst_n, 0);
    checkOutput("async_rst_src", src_hpd, 0);
    checkOutput("async_rst_retry", retry_cnt, 0);
    @(negedge gclk);
    rst = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
